s_acc24_stream: RTL and testbench

- Sequential consumer stage placed directly downstream of the 24-bit signed ripple-carry adder.
- Accepts a stream of signed 24-bit operand pairs over a valid/ready handshake.
- Forms the full 25-bit signed sum of each pair (same bit-exact result as the adder: sign-extended a + b), then accumulates those sums into a signed ACC_W-bit register.
- On the beat marked last, presents the total, beat count and sticky overflow flag on an output valid/ready handshake.

---
 rtl/s_acc24_stream_if.sv | 17 +
 rtl/s_acc24_stream.sv | 78 +++++++
 tb/tb_s_acc24_stream.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/s_acc24_stream_if.sv
// s_acc24_stream_if: operand-beat input and frame-result output handshakes.
interface s_acc24_stream_if #(parameter int ACC_W = 32, parameter int CNT_W = 8);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic signed [23:0]      a;
  logic signed [23:0]      b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;
  modport master (output in_valid, in_last, a, b, out_ready,
                  input  in_ready, out_valid, out_acc, out_count, out_ovf);
  modport slave  (input  in_valid, in_last, a, b, out_ready,
                  output in_ready, out_valid, out_acc, out_count, out_ovf);
endinterface

// File: rtl/s_acc24_stream.sv
// s_acc24_stream: two-stage sum-and-accumulate of signed 24-bit pairs, one frame result per in_last.
module s_acc24_stream #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clr,
  s_acc24_stream_if.slave s
);
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
  state_t                  state;
  logic                    s1_vld;
  logic                    s1_last;
  logic signed [24:0]      s1_sum;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        count;
  logic                    ovf;
  logic                    out_valid;
  logic                    accept;
  assign s.in_ready  = (state == ACCUM) & ~clr;
  assign accept      = s.in_valid & s.in_ready;
  assign addend      = ACC_W'(s1_sum);
  assign acc_nxt     = acc + addend;
  assign s.out_valid = out_valid;
  assign s.out_acc   = acc;
  assign s.out_count = count;
  assign s.out_ovf   = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_sum  <= {s.a[23], s.a} + {s.b[23], s.b};
        s1_last <= s.in_last;
      end
      if (s1_vld) begin
        acc   <= acc_nxt;
        count <= &count ? count : count + 1'b1;
        ovf   <= ovf | ((acc[ACC_W-1] == addend[ACC_W-1]) & (acc_nxt[ACC_W-1] != acc[ACC_W-1]));
      end
      // DRAIN waits one extra cycle after S2 absorbs the last beat so HOLD sees the final total
      case (state)
        ACCUM: if (accept && s.in_last) state <= DRAIN;
        DRAIN: if (!(s1_vld && s1_last)) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (s.out_ready) begin
          state     <= ACCUM;
          out_valid <= 1'b0;
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_s_acc24_stream.sv
// tb_s_acc24_stream: drives one stream into a 32/8 and a 25/2 instance and checks both against an arithmetic model.
module tb_s_acc24_stream;
  logic clk, rst_n, clr;
  logic in_valid, in_last, out_ready;
  logic signed [23:0] a, b;
  int n_chk = 0, n_fail = 0;
  int W[2] = '{32, 25};
  int CW[2] = '{8, 2};
  longint m_acc[2];
  bit m_ovf[2];
  int m_n;
  logic [23:0] fa[$], fb[$];

  s_acc24_stream_if #(.ACC_W(32), .CNT_W(8)) i0 ();
  s_acc24_stream_if #(.ACC_W(25), .CNT_W(2)) i1 ();
  assign i0.in_valid = in_valid;  assign i1.in_valid = in_valid;
  assign i0.in_last = in_last;    assign i1.in_last = in_last;
  assign i0.a = a;                assign i1.a = a;
  assign i0.b = b;                assign i1.b = b;
  assign i0.out_ready = out_ready; assign i1.out_ready = out_ready;

  s_acc24_stream #(.ACC_W(32), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .s(i0.slave));
  s_acc24_stream #(.ACC_W(25), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .s(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrap(longint v, int w);
    longint m = longint'(1) <<< w;
    longint r = v & (m - 1);
    return (r >= (m >>> 1)) ? r - m : r;
  endfunction

  function automatic logic [63:0] e_acc(int k);
    return 64'(m_acc[k]) & ((64'd1 << W[k]) - 64'd1);
  endfunction

  function automatic logic [63:0] e_cnt(int k);
    int mx = (1 << CW[k]) - 1;
    return 64'((m_n > mx) ? mx : m_n);
  endfunction

  task automatic m_reset();
    m_acc = '{0, 0};
    m_ovf = '{0, 0};
    m_n = 0;
  endtask

  task automatic m_beat(logic [23:0] x, logic [23:0] y);
    longint s = longint'($signed(x)) + longint'($signed(y));
    for (int k = 0; k < 2; k++) begin
      longint e = m_acc[k] + s;
      longint hi = (longint'(1) <<< (W[k] - 1)) - 1;
      if (e > hi || e < -hi - 1) m_ovf[k] = 1'b1;
      m_acc[k] = wrap(e, W[k]);
    end
    m_n++;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(logic v);
    chk("out_valid", 64'({i0.out_valid, i1.out_valid}), 64'({v, v}));
    chk("out_acc32", 64'($unsigned(i0.out_acc)), e_acc(0));
    chk("out_acc25", 64'($unsigned(i1.out_acc)), e_acc(1));
    chk("out_count8", 64'(i0.out_count), e_cnt(0));
    chk("out_count2", 64'(i1.out_count), e_cnt(1));
    chk("out_ovf32", 64'(i0.out_ovf), 64'(m_ovf[0]));
    chk("out_ovf25", 64'(i1.out_ovf), 64'(m_ovf[1]));
  endtask

  task automatic chk_ready(string tag, logic r);
    chk(tag, 64'({i0.in_ready, i1.in_ready}), 64'({r, r}));
  endtask

  // Sends the queued beats back-to-back, checks latency and held result, then optionally completes the handshake.
  task automatic run_frame(int bp, bit done);
    for (int i = 0; i < fa.size(); i++) begin
      a = fa[i];
      b = fb[i];
      in_last = (i == fa.size() - 1);
      in_valid = 1'b1;
      chk_ready("in_ready_beat", 1'b1);
      step();
      m_beat(fa[i], fb[i]);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk_ready("in_ready_drain", 1'b0);
    chk("lat_e0", 64'({i0.out_valid, i1.out_valid}), 64'd0);
    step();
    chk("lat_e1", 64'({i0.out_valid, i1.out_valid}), 64'd0);
    step();
    check_out(1'b1);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      a = 24'($urandom);
      b = 24'($urandom);
      step();
      chk_ready("in_ready_hold", 1'b0);
      check_out(1'b1);
    end
    in_valid = 1'b0;
    fa.delete();
    fb.delete();
    if (done) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      m_reset();
      check_out(1'b0);
      chk_ready("in_ready_after", 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    m_reset();
    #12 rst_n = 1'b1;
    step();
    check_out(1'b0);
    chk_ready("in_ready_reset", 1'b1);
    // three-beat frame ending on the largest positive pair
    fa = '{24'd5, 24'hFFFFF6, 24'h7FFFFF};
    fb = '{24'd7, 24'd3, 24'h7FFFFF};
    run_frame(0, 1);
    fa = '{24'h800000};
    fb = '{24'h800000};
    run_frame(0, 1);
    fa = '{24'h7FFFFF, 24'h7FFFFF};
    fb = '{24'h7FFFFF, 24'h7FFFFF};
    run_frame(0, 1);
    // backpressure, then the next frame starts immediately from zero
    for (int i = 0; i < 3; i++) begin fa.push_back(24'($urandom)); fb.push_back(24'($urandom)); end
    run_frame(10, 1);
    for (int i = 0; i < 2; i++) begin fa.push_back(24'($urandom)); fb.push_back(24'($urandom)); end
    run_frame(0, 1);
    // clr while S1 holds a mid-frame beat
    a = 24'd100; b = 24'd200; in_valid = 1'b1; in_last = 1'b0;
    step();
    clr = 1'b1; a = 24'd9; b = 24'd9;
    #0 chk_ready("in_ready_clr", 1'b0);
    step();
    clr = 1'b0; in_valid = 1'b0;
    m_reset();
    check_out(1'b0);
    step();
    check_out(1'b0);
    fa = '{24'd1};
    fb = '{24'd1};
    run_frame(0, 1);
    // five beats saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin fa.push_back(24'd1); fb.push_back(24'd0); end
    run_frame(2, 1);
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin fa.push_back(24'($urandom)); fb.push_back(24'($urandom)); end
      run_frame($urandom_range(0, 3), 1);
    end
    // asynchronous reset while a result is held
    fa = '{24'd3};
    fb = '{24'd4};
    run_frame(1, 0);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    check_out(1'b0);
    #2 rst_n = 1'b1;
    step();
    check_out(1'b0);
    chk_ready("in_ready_rst", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
